// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Multi-cycle instruction sequencer for a simple in-order core. It walks each
// instruction through FETCH -> DECODE -> EXECUTE -> UPDATE. It chooses the
// next program counter from trap, jump, taken branch or the sequential
// address. It also keeps a retired-instruction count and a sticky flag for
// misaligned redirect targets.
//
// Parameters:
//   RESET_VECTOR  first fetch address after reset
//   TRAP_VECTOR   redirect address on trap or misaligned jump/branch target
//
// Ports:
//   clk            system clock, rising-edge active
//   reset          asynchronous, active-high reset
//   pc             current program counter register value
//   fetch_ack      instruction memory returned the word for the pending fetch
//   stall          datapath hazard, holds the sequencer in EXECUTE
//   branch_taken   conditional branch resolved taken
//   branch_target  branch destination
//   jump           unconditional jump
//   jump_target    jump destination
//   trap           exception request, overrides stall
//   fetch_req      instruction fetch request at address pc
//   ir_write       strobe to latch the fetched instruction
//   pc_write       one-cycle enable for the PC register to load pc_next
//   pc_next        next PC value (registered redirect target)
//   misaligned     sticky flag, set when a jump/branch target is misaligned
//   state          current FSM state code, for debug
//   instret        count of retired instructions (wraps silently)
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        fetch_ack,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        trap,
  output logic        fetch_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic [31:0] pc_next,
  output logic        misaligned,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    BOOT    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    UPDATE  = 3'd4
  } state_t;

  state_t      state_q;
  logic        retire_q;
  logic [31:0] sel_target;
  logic        sel_misaligned;
  logic        sel_retire;

  assign state = state_q;

  // The instruction register must capture the word in the same cycle that
  // memory acknowledges it. The strobe therefore follows fetch_ack directly,
  // gated by the registered fetch request. fetch_req is only high in FETCH
  // and is cleared asynchronously by reset. So an ack seen outside FETCH, or
  // while reset is held, can never produce a strobe.
  assign ir_write = fetch_req & fetch_ack;

  // Redirect selection, in priority order: trap, jump, taken branch, then
  // sequential. A misaligned jump or branch target is steered to the trap
  // vector. The flag lets the FSM make misaligned sticky. A trap does not
  // retire an instruction. A misaligned redirect still retires one.
  always_comb begin
    sel_target     = pc + 32'd4;
    sel_misaligned = 1'b0;
    sel_retire     = 1'b1;
    if (trap) begin
      sel_target = TRAP_VECTOR;
      sel_retire = 1'b0;
    end else if (jump) begin
      if (jump_target[1:0] != 2'b00) begin
        sel_target     = TRAP_VECTOR;
        sel_misaligned = 1'b1;
      end else begin
        sel_target = jump_target;
      end
    end else if (branch_taken) begin
      if (branch_target[1:0] != 2'b00) begin
        sel_target     = TRAP_VECTOR;
        sel_misaligned = 1'b1;
      end else begin
        sel_target = branch_target;
      end
    end
  end

  // Main sequencer. All outputs except ir_write are registered alongside the
  // state. Each output therefore changes on the same edge that enters the
  // state it belongs to.
  //
  // BOOT uses pc_write itself as a sub-step. The first cycle in BOOT (straight
  // out of reset, or after recovering from an illegal code) raises pc_write.
  // The second cycle drops pc_write and moves to FETCH. This yields exactly
  // one RESET_VECTOR write, visible while the state still reads BOOT.
  //
  // pc_next doubles as the registered target. It only changes when entering
  // UPDATE or BOOT, so it holds steady through FETCH, DECODE and EXECUTE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      fetch_req  <= 1'b0;
      pc_write   <= 1'b0;
      pc_next    <= RESET_VECTOR;
      misaligned <= 1'b0;
      instret    <= 32'd0;
      retire_q   <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          if (!pc_write) begin
            pc_write <= 1'b1;
            pc_next  <= RESET_VECTOR;
          end else begin
            pc_write  <= 1'b0;
            fetch_req <= 1'b1;
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          if (fetch_ack) begin
            fetch_req <= 1'b0;
            state_q   <= DECODE;
          end
        end
        DECODE: begin
          state_q <= EXECUTE;
        end
        EXECUTE: begin
          if (trap || !stall) begin
            pc_next  <= sel_target;
            retire_q <= sel_retire;
            pc_write <= 1'b1;
            state_q  <= UPDATE;
            if (sel_misaligned) begin
              misaligned <= 1'b1;
            end
          end
        end
        UPDATE: begin
          pc_write  <= 1'b0;
          fetch_req <= 1'b1;
          state_q   <= FETCH;
          if (retire_q) begin
            instret <= instret + 32'd1;
          end
        end
        default: begin
          state_q   <= BOOT;
          pc_write  <= 1'b0;
          fetch_req <= 1'b0;
          pc_next   <= RESET_VECTOR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer. An instruction-level reference model
// keeps the expected PC, retired count and sticky misaligned flag. It lays
// out the cycle schedule of each instruction from its fetch wait and stall
// lengths, then compares every cycle's outputs against that schedule.
// Directed cases come first, followed by randomized instructions.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        fetch_ack;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        trap;
  logic        fetch_req;
  logic        ir_write;
  logic        pc_write;
  logic [31:0] pc_next;
  logic        misaligned;
  logic [2:0]  state;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  logic [31:0] modelPc;
  logic [31:0] expPcNext;
  logic [31:0] expInstret;
  logic        expMis;

  pc_sequencer #(
    .RESET_VECTOR(RV),
    .TRAP_VECTOR (TV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .fetch_ack    (fetch_ack),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .trap         (trap),
    .fetch_req    (fetch_req),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_next      (pc_next),
    .misaligned   (misaligned),
    .state        (state),
    .instret      (instret)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point. It counts every check and reports each mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Compares all outputs against the expectations for one cycle of the schedule.
  task automatic checkPhase(input string ph, input logic [2:0] st, input logic fr,
                            input logic iw, input logic pw, input logic [31:0] pn);
    checkOutput({ph, ".state"},      32'(state),      32'(st));
    checkOutput({ph, ".fetch_req"},  32'(fetch_req),  32'(fr));
    checkOutput({ph, ".ir_write"},   32'(ir_write),   32'(iw));
    checkOutput({ph, ".pc_write"},   32'(pc_write),   32'(pw));
    checkOutput({ph, ".pc_next"},    pc_next,         pn);
    checkOutput({ph, ".misaligned"}, 32'(misaligned), 32'(expMis));
    checkOutput({ph, ".instret"},    instret,         expInstret);
  endtask

  // Drives the given fetch_ack. Stall, jump and branch get random values,
  // which the sequencer must ignore outside EXECUTE. trap is held low.
  task automatic driveQuiet(input logic ack);
    fetch_ack     = ack;
    trap          = 1'b0;
    stall         = 1'($urandom_range(0, 1));
    jump          = 1'($urandom_range(0, 1));
    branch_taken  = 1'($urandom_range(0, 1));
    jump_target   = $urandom;
    branch_target = $urandom;
    pc            = modelPc;
  endtask

  // Puts the reference model back to its post-reset values.
  task automatic modelReset();
    modelPc    = RV;
    expPcNext  = RV;
    expInstret = 32'd0;
    expMis     = 1'b0;
  endtask

  // Checks the single BOOT cycle that writes RESET_VECTOR after reset release.
  task automatic bootCheck();
    @(negedge clk);
    driveQuiet(1'($urandom_range(0, 1)));
    #1;
    checkPhase("boot", 3'd0, 1'b0, 1'b0, 1'b1, RV);
  endtask

  // Runs one instruction through the sequencer.
  //   waitN  : FETCH cycles without an ack before the ack cycle
  //   stallN : EXECUTE cycles with stall held before the resolving cycle
  // The remaining arguments set the redirect inputs on the resolving
  // EXECUTE cycle. trapStall keeps stall high alongside a trap.
  task automatic applyStimulus(input int waitN, input int stallN, input bit doTrap,
                               input bit trapStall, input bit doJump, input logic [31:0] jTgt,
                               input bit doBranch, input logic [31:0] bTgt);
    logic [31:0] tgt;
    bit          ret;
    for (int i = 0; i <= waitN; i++) begin
      @(negedge clk);
      driveQuiet(i == waitN);
      #1;
      checkPhase("fetch", 3'd1, 1'b1, i == waitN, 1'b0, expPcNext);
    end
    @(negedge clk);
    driveQuiet(1'($urandom_range(0, 1)));
    #1;
    checkPhase("decode", 3'd2, 1'b0, 1'b0, 1'b0, expPcNext);
    for (int s = 0; s <= stallN; s++) begin
      @(negedge clk);
      driveQuiet(1'($urandom_range(0, 1)));
      if (s < stallN) begin
        stall = 1'b1;
      end else begin
        stall         = doTrap ? trapStall : 1'b0;
        trap          = doTrap;
        jump          = doJump;
        jump_target   = jTgt;
        branch_taken  = doBranch;
        branch_target = bTgt;
      end
      #1;
      checkPhase("execute", 3'd3, 1'b0, 1'b0, 1'b0, expPcNext);
    end
    ret = 1'b1;
    if (doTrap) begin
      tgt = TV;
      ret = 1'b0;
    end else if (doJump) begin
      tgt = (jTgt % 4 != 0) ? TV : jTgt;
      if (jTgt % 4 != 0) expMis = 1'b1;
    end else if (doBranch) begin
      tgt = (bTgt % 4 != 0) ? TV : bTgt;
      if (bTgt % 4 != 0) expMis = 1'b1;
    end else begin
      tgt = modelPc + 32'd4;
    end
    @(negedge clk);
    driveQuiet(1'($urandom_range(0, 1)));
    #1;
    checkPhase("update", 3'd4, 1'b0, 1'b0, 1'b1, tgt);
    expPcNext = tgt;
    modelPc   = tgt;
    if (ret) expInstret = expInstret + 32'd1;
  endtask

  // Returns a random target, mostly word-aligned.
  function automatic logic [31:0] randTarget();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 3) != 0) v = v & 32'hFFFF_FFFC;
    return v;
  endfunction

  // Main sequence: power-on reset, directed cases, random instructions,
  // then an abort in the middle of a fetch.
  initial begin
    reset         = 1'b1;
    fetch_ack     = 1'b0;
    stall         = 1'b0;
    trap          = 1'b0;
    jump          = 1'b0;
    branch_taken  = 1'b0;
    jump_target   = 32'd0;
    branch_target = 32'd0;
    modelReset();
    pc = modelPc;

    repeat (2) @(negedge clk);
    #1;
    checkPhase("por", 3'd0, 1'b0, 1'b0, 1'b0, RV);
    @(negedge clk);
    reset = 1'b0;
    bootCheck();

    // Straight-line run: pc_next goes 4, 8, 12 and three instructions retire.
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 32'd0, 0, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("instret_after3", instret, 32'd3);

    // Jump beats a taken branch.
    applyStimulus(1, 0, 0, 0, 1, 32'h80, 1, 32'h40);
    checkOutput("jump_over_branch", pc_next, 32'h80);

    // Stall, then a trap while still stalled: redirects to the trap vector
    // without retiring.
    applyStimulus(0, 1, 1, 1, 0, 32'd0, 0, 32'd0);
    checkOutput("trap_target", pc_next, TV);

    // Misaligned jump goes to the trap vector and the flag stays set.
    applyStimulus(0, 0, 0, 0, 1, 32'h42, 0, 32'd0);
    checkOutput("misaligned_set", 32'(misaligned), 32'd1);
    applyStimulus(2, 2, 0, 0, 0, 32'd0, 1, 32'h200);
    checkOutput("misaligned_sticky", 32'(misaligned), 32'd1);

    // Sequential address wraps at the top of the address space.
    modelPc = 32'hFFFF_FFFC;
    applyStimulus(0, 0, 0, 0, 0, 32'd0, 0, 32'd0);
    checkOutput("pc_wrap", pc_next, 32'h0000_0000);

    // Randomized instructions.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) modelPc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 19) == 0) modelPc = 32'hFFFF_FFFC;
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0), randTarget(),
                    ($urandom_range(0, 2) == 0), randTarget());
    end

    // Hold the fetch unacknowledged for five cycles. Then assert reset in
    // the middle of a cycle with an ack pending.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      driveQuiet(1'b0);
      #1;
      checkPhase("hold", 3'd1, 1'b1, 1'b0, 1'b0, expPcNext);
    end
    #2;
    reset     = 1'b1;
    fetch_ack = 1'b1;
    modelReset();
    pc = modelPc;
    #1;
    checkPhase("midreset", 3'd0, 1'b0, 1'b0, 1'b0, RV);
    @(negedge clk);
    #1;
    checkPhase("midreset_hold", 3'd0, 1'b0, 1'b0, 1'b0, RV);
    reset = 1'b0;
    bootCheck();
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 32'd0, 0, 32'd0);
    checkOutput("after_reset_pc", pc_next, 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
